tff_excitation_driver: RTL and testbench

//  Drives the T inputs of a bank of WIDTH T flip-flops so the bank reaches a requested target word.

---
 rtl/tff_drv_pkg.sv | 21 ++
 rtl/tff_flip_picker.sv | 24 ++
 rtl/tff_excitation_driver.sv | 116 +++++++++++
 tb/tb_tff_excitation_driver.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/tff_drv_pkg.sv
// Shared types and helpers for the T-flop excitation driver.
package tff_drv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned DEF_MAX_FLIPS = 2;

  function automatic int unsigned popcount(input logic [63:0] v);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < 64; i++) begin
      n += int'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/tff_flip_picker.sv
// Combinational picker: passes through the lowest MAX_FLIPS set bits of remaining.
module tff_flip_picker
  import tff_drv_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_FLIPS = DEF_MAX_FLIPS
) (
  input  logic [WIDTH-1:0] remaining,
  output logic [WIDTH-1:0] pick
);

  always_comb begin
    int unsigned n_sel;
    pick  = '0;
    n_sel = 0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (remaining[i] && (n_sel < MAX_FLIPS)) begin
        pick[i] = 1'b1;
        n_sel++;
      end
    end
  end

endmodule

// File: rtl/tff_excitation_driver.sv
// Steps a T-flop bank toward a requested word, at most MAX_FLIPS toggles per cycle.
// Optional SR excitation outputs (s_out/r_out) are built when TFF_SR_OUT_EN is defined.
module tff_excitation_driver
  import tff_drv_pkg::*;
#(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      MAX_FLIPS = DEF_MAX_FLIPS,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tgt_valid,
  input  logic [WIDTH-1:0] tgt_data,
  output logic             tgt_ready,
  output logic [WIDTH-1:0] t_out,
  output logic [WIDTH-1:0] shadow_q,
  output logic             busy,
  output logic             done
`ifdef TFF_SR_OUT_EN
  ,
  output logic [WIDTH-1:0] s_out,
  output logic [WIDTH-1:0] r_out
`endif
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [WIDTH-1:0] r_remaining;
  logic [WIDTH-1:0] r_t_out;
  logic [WIDTH-1:0] r_shadow;
  logic             r_done;
  logic [WIDTH-1:0] w_pick;
  logic [WIDTH-1:0] w_left;
  logic             w_accept;

  tff_flip_picker #(
    .WIDTH     (WIDTH),
    .MAX_FLIPS (MAX_FLIPS)
  ) u_picker (
    .remaining (r_remaining),
    .pick      (w_pick)
  );

  assign w_left   = r_remaining & ~w_pick;
  assign w_accept = tgt_valid && (r_state == IDLE);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = ((tgt_data ^ r_shadow) == '0) ? DONE : STEP;
        end
      end
      STEP: begin
        if (w_left == '0) begin
          w_state_nxt = DONE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // done is registered from the next state so it coincides with the DONE cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_remaining <= '0;
      r_t_out     <= '0;
      r_shadow    <= RESET_VAL;
      r_done      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_t_out <= '0;
      r_done  <= (w_state_nxt == DONE);
      if (w_accept) begin
        r_remaining <= tgt_data ^ r_shadow;
      end
      if (r_state == STEP) begin
        r_t_out     <= w_pick;
        r_shadow    <= r_shadow ^ w_pick;
        r_remaining <= w_left;
      end
    end
  end

`ifdef TFF_SR_OUT_EN
  logic [WIDTH-1:0] r_s_out;
  logic [WIDTH-1:0] r_r_out;

  // Set/reset are split against the pre-toggle shadow, so they are disjoint by construction.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_s_out <= '0;
      r_r_out <= '0;
    end else if (r_state == STEP) begin
      r_s_out <= w_pick & ~r_shadow;
      r_r_out <= w_pick & r_shadow;
    end else begin
      r_s_out <= '0;
      r_r_out <= '0;
    end
  end

  assign s_out = r_s_out;
  assign r_out = r_r_out;
`endif

  assign t_out     = r_t_out;
  assign shadow_q  = r_shadow;
  assign done      = r_done;
  assign busy      = (r_state != IDLE);
  assign tgt_ready = (r_state == IDLE);

endmodule

// File: tb/tb_tff_excitation_driver.sv
// Self-checking bench for tff_excitation_driver (WIDTH=8, MAX_FLIPS=2).
module tb_tff_excitation_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tgt_valid = 1'b0;
  logic [7:0] tgt_data = '0;
  logic       tgt_ready;
  logic [7:0] t_out;
  logic [7:0] shadow_q;
  logic       busy;
  logic       done;
`ifdef TFF_SR_OUT_EN
  logic [7:0] s_out;
  logic [7:0] r_out;
  logic [7:0] s_union;
  logic [7:0] r_union;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] sh_model;
  logic [7:0] bank;

  always #5 clk = ~clk;

  tff_excitation_driver #(
    .WIDTH     (8),
    .MAX_FLIPS (2),
    .RESET_VAL (8'hFF)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tgt_valid (tgt_valid),
    .tgt_data  (tgt_data),
    .tgt_ready (tgt_ready),
    .t_out     (t_out),
    .shadow_q  (shadow_q),
    .busy      (busy),
    .done      (done)
`ifdef TFF_SR_OUT_EN
    ,
    .s_out     (s_out),
    .r_out     (r_out)
`endif
  );

  // Independent model of the physical T-flop bank fed by t_out.
  always @(posedge clk) begin
    if (!rst) bank <= 8'hFF;
    else      bank <= bank ^ t_out;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cycle(input logic [7:0] tout_e, input logic [7:0] sh_e,
                             input logic done_e, input logic busy_e, input logic rdy_e);
    chk("t_out", t_out, tout_e);
    chk("shadow_q", shadow_q, sh_e);
    chk("done", done, done_e);
    chk("busy", busy, busy_e);
    chk("tgt_ready", tgt_ready, rdy_e);
    chk("bank_vs_shadow", shadow_q, bank ^ t_out);
`ifdef TFF_SR_OUT_EN
    chk("s_and_r", s_out & r_out, 8'h00);
    chk("s_out", s_out, tout_e & ~(sh_e ^ tout_e));
    chk("r_out", r_out, tout_e & (sh_e ^ tout_e));
    s_union = s_union | s_out;
    r_union = r_union | r_out;
`endif
  endtask

  // One request: wait for ready, accept, then check every cycle to the first idle cycle.
  task automatic do_req(input logic [7:0] tgt, input bit keep, input logic [7:0] nxt);
    logic [7:0] d, b1, rest, b2, p, cur;
    logic [7:0] pulses[$];
    int         w;
    tgt_valid = 1'b1;
    tgt_data  = tgt;
    w = 0;
    while (tgt_ready !== 1'b1 && w < 64) begin
      tick();
      w++;
    end
    chk("ready_timeout", (w < 64), 1);
    d = tgt ^ sh_model;
    while (d != 8'h00) begin
      b1   = d & (~d + 8'd1);
      rest = d ^ b1;
      b2   = rest & (~rest + 8'd1);
      p    = b1 | b2;
      pulses.push_back(p);
      d = d & ~p;
    end
    tick();
    if (keep) tgt_data = nxt;
    else      tgt_valid = 1'b0;
    cur = sh_model;
    for (int c = 1; c <= pulses.size() + 1; c++) begin
      logic [7:0] te;
      te  = (c >= 2) ? pulses[c-2] : 8'h00;
      cur = cur ^ te;
      check_cycle(te, cur, (c == pulses.size() + 1), 1'b1, 1'b0);
      tick();
    end
    check_cycle(8'h00, cur, 1'b0, 1'b0, 1'b1);
    chk("final_shadow", shadow_q, tgt);
    sh_model = tgt;
  endtask

  initial begin
    rst = 1'b0;
    tick();
    tick();
    check_cycle(8'h00, 8'hFF, 1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    sh_model = 8'hFF;
    tick();

    do_req(8'hFF, 1'b0, 8'h00);
    do_req(8'h00, 1'b0, 8'h00);
    do_req(8'h80, 1'b0, 8'h00);

    do_req(8'hAA, 1'b1, 8'h55);
    do_req(8'h55, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_cycle(8'h00, 8'h55, 1'b0, 1'b0, 1'b1);
    end

    // Reset in the second STEP cycle of an FF -> 00 change.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    tgt_valid = 1'b1;
    tgt_data  = 8'h00;
    chk("rst_pre_ready", tgt_ready, 1);
    tick();
    tgt_valid = 1'b0;
    check_cycle(8'h00, 8'hFF, 1'b0, 1'b1, 1'b0);
    tick();
    check_cycle(8'h03, 8'hFC, 1'b0, 1'b1, 1'b0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check_cycle(8'h00, 8'hFF, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_cycle(8'h00, 8'hFF, 1'b0, 1'b0, 1'b1);
    end
    sh_model = 8'hFF;

`ifdef TFF_SR_OUT_EN
    do_req(8'hF0, 1'b0, 8'h00);
    s_union = '0;
    r_union = '0;
    do_req(8'h0F, 1'b0, 8'h00);
    chk("s_union", s_union, 8'h0F);
    chk("r_union", r_union, 8'hF0);
`endif

    for (int i = 0; i < 24; i++) begin
      logic [7:0] t;
      int         gap;
      t   = 8'($urandom);
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) tick();
      do_req(t, 1'b0, 8'h00);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
